// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-player frame-driven motion/action sequencer (walk, jump arc,
// squat, shield energy, fire cooldown). Define PLAYER_DOUBLE_JUMP_EN to allow one air jump per airtime.
module player_motion_ctrl #(
    parameter logic [3:0] BASE_ID    = 4'd1,
    parameter int         INIT_X     = -500,
    parameter bit         FACE_RIGHT = 1'b1,
    parameter int         STEP       = 4,
    parameter int         JUMP_V     = 20,
    parameter int         MAX_H      = 80,
    parameter int         LIM_X      = 600,
    parameter int         GRAV       = 2,
    parameter int         SHIELD_MAX = 60,
    parameter int         COOLDOWN   = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_game_en,
    input  logic        i_frame_tick,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_jump,
    input  logic        i_squat,
    input  logic        i_shield,
    input  logic        i_fire,
    output logic [10:0] o_x,
    output logic [7:0]  o_y,
    output logic [3:0]  o_object_id,
    output logic        o_fire,
    output logic        o_bullet_dir,
    output logic [6:0]  o_shield_energy
);
    typedef enum logic [2:0] {
        ST_GROUND,
        ST_SQUAT,
        ST_SHIELD,
        ST_RISE,
        ST_FALL
    } state_t;

    localparam logic signed [10:0] X_INIT  = 11'(INIT_X);
    localparam logic signed [11:0] X_LIM_P = 12'(LIM_X);
    localparam logic signed [11:0] X_LIM_N = 12'(-LIM_X);
    localparam logic signed [11:0] X_STEP  = 12'(STEP);
    localparam logic signed [8:0]  V_JUMP  = 9'(JUMP_V);
    localparam logic signed [8:0]  V_GRAV  = 9'(GRAV);
    localparam logic signed [8:0]  Y_MAX   = 9'(MAX_H);
    localparam logic [6:0]         E_MAX   = 7'(SHIELD_MAX);
    localparam logic [6:0]         E_HALF  = 7'(SHIELD_MAX / 2);
    localparam logic [7:0]         CD_MAX  = 8'(COOLDOWN);

    state_t             state_reg, state_next;
    logic signed [10:0] x_reg, x_next;
    logic [7:0]         y_reg, y_next;
    logic signed [8:0]  vy_reg, vy_next;
    logic [6:0]         energy_reg, energy_next;
    logic               lockout_reg, lockout_next;
    logic [7:0]         cooldown_reg, cooldown_next;
    logic               fire_reg, fire_next;
    logic [3:0]         id_reg, id_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic               jump_prev_reg, jump_prev_next;
    logic               air_jump_reg, air_jump_next;
`endif

    logic signed [11:0] x_wide;
    logic signed [8:0]  y_wide;
    logic signed [8:0]  vy_wide;
    logic               moving;

    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        vy_next       = vy_reg;
        energy_next   = energy_reg;
        lockout_next  = lockout_reg;
        cooldown_next = cooldown_reg;
        fire_next     = 1'b0;
        id_next       = id_reg;
        x_wide        = {x_reg[10], x_reg};
        y_wide        = '0;
        vy_wide       = vy_reg;
        moving        = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
        jump_prev_next = jump_prev_reg;
        air_jump_next  = air_jump_reg;
`endif
        if (i_frame_tick) begin
            // Energy follows the state held going into this tick.
            if (state_reg == ST_SHIELD) begin
                if (energy_reg != 7'd0) begin
                    energy_next = energy_reg - 7'd1;
                end
            end else if (energy_reg < E_MAX) begin
                energy_next = energy_reg + 7'd1;
            end
            lockout_next = lockout_reg && (energy_next < E_HALF);

            case (state_reg)
                ST_RISE, ST_FALL: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (i_jump && !jump_prev_reg && !air_jump_reg) begin
                        state_next    = ST_RISE;
                        vy_next       = V_JUMP;
                        air_jump_next = 1'b1;
                    end else
`endif
                    if (state_reg == ST_RISE) begin
                        y_wide = $signed({1'b0, y_reg}) + vy_reg;
                        if (y_wide > Y_MAX) begin
                            y_wide = Y_MAX;
                        end
                        vy_wide = vy_reg - V_GRAV;
                        y_next  = y_wide[7:0];
                        if (y_wide == Y_MAX || vy_wide <= 9'sd0) begin
                            state_next = ST_FALL;
                            vy_next    = '0;
                        end else begin
                            vy_next = vy_wide;
                        end
                    end else begin
                        vy_wide = vy_reg + V_GRAV;
                        y_wide  = $signed({1'b0, y_reg}) - vy_wide;
                        if (y_wide <= 9'sd0) begin
                            y_next     = 8'd0;
                            vy_next    = '0;
                            state_next = ST_GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            air_jump_next = 1'b0;
`endif
                        end else begin
                            y_next  = y_wide[7:0];
                            vy_next = vy_wide;
                        end
                    end
                end
                default: begin
                    // Draining the last unit of energy overrides any held request.
                    if (state_reg == ST_SHIELD && energy_next == 7'd0) begin
                        state_next   = ST_GROUND;
                        lockout_next = 1'b1;
                    end else if (i_shield && energy_reg != 7'd0 && !lockout_reg) begin
                        state_next = ST_SHIELD;
                    end else if (i_squat) begin
                        state_next = ST_SQUAT;
                    end else if (i_jump) begin
                        state_next = ST_RISE;
                        vy_next    = V_JUMP;
                    end else begin
                        state_next = ST_GROUND;
                    end
                end
            endcase

            moving = (state_next != ST_SQUAT) && (state_next != ST_SHIELD);
            if (moving && i_left && !i_right) begin
                x_wide = x_wide - X_STEP;
            end else if (moving && i_right && !i_left) begin
                x_wide = x_wide + X_STEP;
            end
            if (x_wide > X_LIM_P) begin
                x_wide = X_LIM_P;
            end else if (x_wide < X_LIM_N) begin
                x_wide = X_LIM_N;
            end
            x_next = x_wide[10:0];

            if (cooldown_reg != 8'd0) begin
                cooldown_next = cooldown_reg - 8'd1;
            end else if (i_fire && state_next != ST_SHIELD) begin
                fire_next     = 1'b1;
                cooldown_next = CD_MAX;
            end

            case (state_next)
                ST_SHIELD: id_next = BASE_ID + 4'd1;
                ST_SQUAT:  id_next = BASE_ID + 4'd2;
                default:   id_next = BASE_ID;
            endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
            jump_prev_next = i_jump;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_GROUND;
            x_reg        <= X_INIT;
            y_reg        <= 8'd0;
            vy_reg       <= '0;
            energy_reg   <= E_MAX;
            lockout_reg  <= 1'b0;
            cooldown_reg <= 8'd0;
            fire_reg     <= 1'b0;
            id_reg       <= BASE_ID;
`ifdef PLAYER_DOUBLE_JUMP_EN
            jump_prev_reg <= 1'b0;
            air_jump_reg  <= 1'b0;
`endif
        end else if (!i_game_en) begin
            state_reg    <= ST_GROUND;
            x_reg        <= X_INIT;
            y_reg        <= 8'd0;
            vy_reg       <= '0;
            energy_reg   <= E_MAX;
            lockout_reg  <= 1'b0;
            cooldown_reg <= 8'd0;
            fire_reg     <= 1'b0;
            id_reg       <= BASE_ID;
`ifdef PLAYER_DOUBLE_JUMP_EN
            jump_prev_reg <= 1'b0;
            air_jump_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            vy_reg       <= vy_next;
            energy_reg   <= energy_next;
            lockout_reg  <= lockout_next;
            cooldown_reg <= cooldown_next;
            fire_reg     <= fire_next;
            id_reg       <= id_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
            jump_prev_reg <= jump_prev_next;
            air_jump_reg  <= air_jump_next;
`endif
        end
    end

    assign o_x             = x_reg;
    assign o_y             = y_reg;
    assign o_object_id     = id_reg;
    assign o_fire          = fire_reg;
    assign o_bullet_dir    = FACE_RIGHT;
    assign o_shield_energy = energy_reg;

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-player motion/action sequencer for the two-player shooter; one instance per player.
- Advances once per frame on `i_frame_tick`: walk, jump arc, squat, shield (with energy budget) and bullet-fire cooldown.
- Outputs registered position and the sprite ObjectID (PLAYER / SHIELD / SQUAT) consumed by the renderer, and a fire pulse consumed by the bullet logic.

Parameters:
- BASE_ID, 4'd1: ObjectID of the standing sprite. Use 1 for player 1, 4 for player 2. SHIELD sprite = BASE_ID+1, SQUAT sprite = BASE_ID+2.
- INIT_X, -500: reset/re-init x (signed).
- FACE_RIGHT, 1: 1 means bullets travel +x, 0 means -x.
- STEP, 4: horizontal step per frame (game_pkg STEP_X).
- JUMP_V, 20: initial jump velocity (game_pkg V).
- MAX_H, 80: jump height ceiling (game_pkg MAX_J).
- LIM_X, 600: x is clamped to [-LIM_X, +LIM_X] (game_pkg LIMIT_X).
- GRAV, 2: velocity change per frame.
- SHIELD_MAX, 60: shield energy capacity, in frames.
- COOLDOWN, 15: frames between shots.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_game_en, in, 1: 0 holds the block in the re-init state.
- i_frame_tick, in, 1: one-cycle pulse per frame; all game updates occur on it.
- i_left, in, 1: move-left level.
- i_right, in, 1: move-right level.
- i_jump, in, 1: jump level.
- i_squat, in, 1: squat level.
- i_shield, in, 1: shield level.
- i_fire, in, 1: fire level.
- o_x, out, 11: signed x position.
- o_y, out, 8: height above ground, 0..MAX_H.
- o_object_id, out, 4: sprite ID.
- o_fire, out, 1: one-cycle spawn pulse.
- o_bullet_dir, out, 1: = FACE_RIGHT.
- o_shield_energy, out, 7: remaining shield energy.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_x=INIT_X, o_y=0, state=GROUND, vy=0.
  - energy=SHIELD_MAX, lockout=0, cooldown=0.
  - o_object_id=BASE_ID, o_fire=0.
- i_game_en=0: same values are loaded synchronously every clock, independent of the tick.
- All inputs are sampled only when i_frame_tick=1. Updated outputs are visible the cycle after the tick. o_fire is high exactly that one cycle.
- States: GROUND, SQUAT, SHIELD, RISE, FALL.
- GROUND, SQUAT and SHIELD re-evaluate every tick with priority SHIELD > SQUAT > JUMP > MOVE:
  - Shield: i_shield=1 and energy>0 and lockout=0 → SHIELD. No x motion, no fire.
  - Squat: else if i_squat=1 → SQUAT. No x motion, no jump; fire allowed.
  - Jump: else if i_jump=1 → RISE with vy=JUMP_V. x motion applies the same tick.
  - Otherwise → GROUND.
- RISE, each tick:
  - y=min(y+vy, MAX_H), then vy=vy-GRAV.
  - Go to FALL with vy=0 when y reaches MAX_H or vy≤0.
- FALL, each tick:
  - vy=vy+GRAV first, then y=max(y-vy, 0).
  - y=0 → GROUND.
- Horizontal motion (GROUND, RISE, FALL only):
  - left-only: x-STEP; right-only: x+STEP; both or neither: no change.
  - Saturates at ±LIM_X; there is no wrap.
- Shield energy, per tick:
  - −1 while in SHIELD.
  - Otherwise +1, saturating at SHIELD_MAX.
  - Hitting 0 forces exit to GROUND the same tick and sets lockout.
  - lockout clears when energy ≥ SHIELD_MAX/2.
- Fire, per tick:
  - cooldown>0 → decrement.
  - Else if i_fire=1 and state≠SHIELD → o_fire=1 and cooldown=COOLDOWN.
  - Holding fire therefore produces one shot per COOLDOWN+1 ticks.
- o_object_id: SHIELD → BASE_ID+1; SQUAT → BASE_ID+2; any other state → BASE_ID.
- Arithmetic: x uses 12-bit signed intermediates before the clamp; y and vy use 9-bit signed intermediates.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- Defined: one extra jump is allowed per airtime.
  - A rising edge of i_jump (sampled tick-to-tick) while in RISE or FALL with the air-jump flag clear → RISE, vy=JUMP_V, flag set.
  - The flag clears on landing (entering GROUND).
- Undefined: i_jump is ignored while airborne; no flag logic exists.

Test Plan:
- Reset then 3 ticks with no inputs → x=-500, y=0, id=1, energy=60, o_fire never asserted.
- Jump held one tick from GROUND → y over ticks: 20, 38, 54, 68, 80, then FALL 78, 74, 68, 60, 50, 38, 24, 8, 0 → GROUND.
- Right held 300 ticks from x=-500 → x=600 at tick 275 and stays 600. Left+right together → x unchanged.
- Shield held 70 ticks → id=2 for 60 ticks, energy 0 forces id=1. Shield still held → stays GROUND until energy reaches 30, then re-enters SHIELD.
- Fire held 40 ticks (standing, BASE_ID=4 instance, FACE_RIGHT=0) → o_fire pulses at ticks 1, 17, 33; o_bullet_dir=0. Fire while shielding → no pulse.
- i_game_en dropped mid-RISE at y=54 → next clock y=0, x=INIT_X, state GROUND, independent of tick.
